// File: rtl/timer_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : timer_arbiter
// Purpose  : Shares one one-shot 64-bit timer among N_CH requesters. Each
//            requester posts a delay; the arbiter grants one request at a time,
//            programs the compare value, starts the timer, waits for done and
//            pulses a per-channel expiry strobe.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk             in   system clock
//   rst             in   synchronous active-high reset
//   req_valid       in   [N_CH]    per-channel request, held until req_accept
//   req_delay       in   [N_CH*W]  flat delays, channel i at [i*W +: W]
//   req_cancel      in   [N_CH]    abort pending / active request
//   req_accept      out  [N_CH]    one-cycle pulse: request latched
//   expire          out  [N_CH]    one-cycle pulse: delay elapsed
//   busy            out            a request is in service
//   active_ch       out  [clog2]   channel in service (valid when busy)
//   tmr_cmp_value   out  [W]       timer compare value
//   tmr_start       out            one-cycle timer start pulse
//   tmr_en          out            timer enable
//   tmr_int_en      out            timer interrupt enable (always 0)
//   tmr_auto_reload out            timer auto reload (always 0, one-shot)
//   tmr_done        in             timer done flag
// Configuration
//   TIMER_ARB_FIXED_PRIO_EN : when defined, arbitration is fixed priority
//                             (lowest index wins) instead of round-robin.
// ============================================================================
module timer_arbiter #(
  parameter int N_CH = 4,
  parameter int W    = 64
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_CH-1:0]           req_valid,
  input  logic [N_CH*W-1:0]         req_delay,
  input  logic [N_CH-1:0]           req_cancel,
  output logic [N_CH-1:0]           req_accept,
  output logic [N_CH-1:0]           expire,
  output logic                      busy,
  output logic [$clog2(N_CH)-1:0]   active_ch,
  output logic [W-1:0]              tmr_cmp_value,
  output logic                      tmr_start,
  output logic                      tmr_en,
  output logic                      tmr_int_en,
  output logic                      tmr_auto_reload,
  input  logic                      tmr_done
);

  localparam int CH_W = $clog2(N_CH);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD   = 3'd1;
  localparam logic [2:0] S_START  = 3'd2;
  localparam logic [2:0] S_SETTLE = 3'd3;
  localparam logic [2:0] S_WAIT   = 3'd4;
  localparam logic [2:0] S_FIN    = 3'd5;

  logic [2:0]      r_state;
  logic [CH_W-1:0] r_active;
  logic [W-1:0]    r_delay;
  logic [W-1:0]    r_cmp;
  logic            r_busy;
  logic            r_en;
  logic            r_start;
  logic [N_CH-1:0] r_accept;
  logic [N_CH-1:0] r_expire;

  logic [N_CH-1:0] w_elig;
  logic            w_any;
  logic [CH_W-1:0] w_winner;
  logic [N_CH-1:0] w_win_onehot;
  logic [N_CH-1:0] w_act_onehot;
  logic [W-1:0]    w_win_delay;
  logic            w_cancel_act;

  // A cancel on a non-active channel only hides it from this cycle's pick.
  assign w_elig = req_valid & ~req_cancel;
  assign w_any  = |w_elig;

`ifdef TIMER_ARB_FIXED_PRIO_EN
  always_comb begin
    w_winner = '0;
    for (int k = N_CH - 1; k >= 0; k--) begin
      if (w_elig[k]) w_winner = CH_W'(k);
    end
  end
`else
  logic [CH_W-1:0] r_ptr;

  // First pass finds the lowest eligible index (the wrap-around fallback);
  // the second pass overrides it with the lowest eligible index >= r_ptr.
  always_comb begin
    w_winner = '0;
    for (int k = N_CH - 1; k >= 0; k--) begin
      if (w_elig[k]) w_winner = CH_W'(k);
    end
    for (int k = N_CH - 1; k >= 0; k--) begin
      if (w_elig[k] && (CH_W'(k) >= r_ptr)) w_winner = CH_W'(k);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= '0;
    end else if ((r_state == S_IDLE) && w_any) begin
      r_ptr <= (w_winner == CH_W'(N_CH - 1)) ? '0 : w_winner + CH_W'(1);
    end
  end
`endif

  always_comb begin
    w_win_onehot = '0;
    w_act_onehot = '0;
    w_win_delay  = '0;
    for (int k = 0; k < N_CH; k++) begin
      w_win_onehot[k] = (CH_W'(k) == w_winner);
      w_act_onehot[k] = (CH_W'(k) == r_active);
      if (CH_W'(k) == w_winner) w_win_delay = req_delay[k*W +: W];
    end
  end

  assign w_cancel_act = |(req_cancel & w_act_onehot);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_active <= '0;
      r_delay  <= '0;
      r_cmp    <= '0;
      r_busy   <= 1'b0;
      r_en     <= 1'b0;
      r_start  <= 1'b0;
      r_accept <= '0;
      r_expire <= '0;
    end else begin
      r_accept <= '0;
      r_expire <= '0;
      r_start  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_accept <= w_win_onehot;
            r_active <= w_winner;
            r_delay  <= w_win_delay;
            r_busy   <= 1'b1;
            r_state  <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (w_cancel_act) begin
            r_en    <= 1'b0;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_cmp <= r_delay;
            r_en  <= 1'b1;
            // A zero delay has already elapsed; skip the timer entirely.
            if (r_delay == '0) begin
              r_state <= S_FIN;
            end else begin
              r_start <= 1'b1;
              r_state <= S_START;
            end
          end
        end
        S_START, S_SETTLE: begin
          // SETTLE ignores tmr_done, which may still be stale from the last run.
          if (w_cancel_act) begin
            r_en    <= 1'b0;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_state <= (r_state == S_START) ? S_SETTLE : S_WAIT;
          end
        end
        S_WAIT: begin
          // Cancel wins over a simultaneous done.
          if (w_cancel_act) begin
            r_en    <= 1'b0;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else if (tmr_done) begin
            r_state <= S_FIN;
          end
        end
        S_FIN: begin
          r_expire <= w_act_onehot;
          r_en     <= 1'b0;
          r_busy   <= 1'b0;
          r_state  <= S_IDLE;
        end
        default: begin
          r_en    <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign req_accept      = r_accept;
  assign expire          = r_expire;
  assign busy            = r_busy;
  assign active_ch       = r_active;
  assign tmr_cmp_value   = r_cmp;
  assign tmr_start       = r_start;
  assign tmr_en          = r_en;
  assign tmr_int_en      = 1'b0;
  assign tmr_auto_reload = 1'b0;

endmodule
`default_nettype wire
